// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        FD_IDLE,
        FD_LAUNCH,
        FD_WAIT
    } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with registered read data and level count
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] LVL_ONE  = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_level;
    logic [DATA_W-1:0] r_rd_data;

    logic w_wr;
    logic w_rd;

    // flush wins over both ports so a cleared FIFO never sees a stray write or pop
    assign w_wr = wr_en && !full && !flush;
    assign w_rd = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign level   = r_level;
    assign empty   = (r_level == '0);
    assign full    = (r_level == LVL_FULL);

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte buffer and launch sequencer in front of the UART transmitter
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     flush,
    input  logic                     tx_en,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_din,
    input  logic                     tx_done_tick,
    output logic                     tx_busy,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    feeder_state_t r_state;
    feeder_state_t w_state_next;

    logic w_pop;
    logic w_wr_en;
    logic w_empty;
    logic w_full;

    assign wr_ready = !w_full && !flush;
    assign w_wr_en  = wr_valid && wr_ready;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .wr_en   (w_wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (tx_din),
        .empty   (w_empty),
        .full    (w_full),
        .level   (level)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= FD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // the pop loads tx_din one cycle before LAUNCH, so the byte is stable for the whole frame
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            FD_IDLE: begin
                if (!w_empty && tx_en && !flush) begin
                    w_pop        = 1'b1;
                    w_state_next = FD_LAUNCH;
                end
            end
            FD_LAUNCH: begin
                w_state_next = FD_WAIT;
            end
            FD_WAIT: begin
                if (tx_done_tick) begin
                    w_state_next = FD_IDLE;
                end
            end
            default: begin
                w_state_next = FD_IDLE;
            end
        endcase
    end

    assign tx_start = (r_state == FD_LAUNCH);
    assign tx_busy  = (r_state != FD_IDLE);
    assign empty    = w_empty;
    assign full     = w_full;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          flush;
    logic          tx_en;
    logic          tx_start;
    logic [DW-1:0] tx_din;
    logic          tx_done_tick;
    logic          tx_busy;
    logic          empty;
    logic          full;
    logic [4:0]    level;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .flush        (flush),
        .tx_en        (tx_en),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .tx_busy      (tx_busy),
        .empty        (empty),
        .full         (full),
        .level        (level)
    );

    int total = 0;
    int bad   = 0;

    // reference: queue holds buffered bytes; m_ph 0=free, 1=launch cycle, 2=frame in flight
    logic [7:0] m_q[$];
    int         m_ph = 0;
    logic [7:0] m_din = 8'h00;

    logic [7:0] launched[$];
    int         start_idx[$];
    int         cyc_no   = 0;
    int         done_lat = 0;
    int         done_at  = -1;

    typedef struct {
        logic       rn;
        logic       wv;
        logic [7:0] wd;
        logic       fl;
        logic       en;
        logic       dn;
        logic       rdy;
        logic       st;
        logic [7:0] din;
        logic       bsy;
        logic       emp;
        logic       ful;
        logic [4:0] lvl;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_no, act, exp);
        end
    endtask

    function automatic logic auto_dn();
        return (done_at == cyc_no + 1);
    endfunction

    task automatic cyc(input logic rn, input logic wv, input logic [7:0] wd,
                       input logic fl, input logic en, input logic dn);
        bit pop;
        bit wr;
        reset_n      = rn;
        wr_valid     = wv;
        wr_data      = wd;
        flush        = fl;
        tx_en        = en;
        tx_done_tick = dn;
        @(posedge clk);
        if (!rn) begin
            m_q.delete();
            m_ph  = 0;
            m_din = 8'h00;
        end else begin
            pop = (m_ph == 0) && (m_q.size() > 0) && en && !fl;
            wr  = wv && !fl && (m_q.size() < DEPTH);
            case (m_ph)
                0:       if (pop) m_ph = 1;
                1:       m_ph = 2;
                default: if (dn) m_ph = 0;
            endcase
            if (fl) begin
                m_q.delete();
            end else begin
                if (pop) m_din = m_q.pop_front();
                if (wr)  m_q.push_back(wd);
            end
        end
        #1;
        cyc_no++;
        chk("wr_ready", wr_ready, (m_q.size() < DEPTH) && !fl);
        chk("tx_start", tx_start, m_ph == 1);
        chk("tx_busy",  tx_busy,  m_ph != 0);
        chk("tx_din",   tx_din,   m_din);
        chk("level",    level,    m_q.size());
        chk("empty",    empty,    m_q.size() == 0);
        chk("full",     full,     m_q.size() == DEPTH);
        if (tx_start === 1'b1) begin
            launched.push_back(tx_din);
            start_idx.push_back(cyc_no);
        end
        if (m_ph == 1 && done_lat > 0) done_at = cyc_no + done_lat;
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, en, auto_dn());
    endtask

    task automatic do_reset(input int lat);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        done_lat = lat;
        done_at  = -1;
        launched.delete();
        start_idx.delete();
    endtask

    initial begin
        reset_n = 1'b0; wr_valid = 1'b0; wr_data = '0;
        flush = 1'b0; tx_en = 1'b0; tx_done_tick = 1'b0;

        // rn wv wd fl en dn | rdy st din bsy emp ful lvl  (each row: outputs after that edge)
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[2]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 5'd0};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 5'd0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 5'd0};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[8]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[9]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 5'd0};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].rn, tbl[i].wv, tbl[i].wd, tbl[i].fl, tbl[i].en, tbl[i].dn);
            chk("vec_rdy",   wr_ready, tbl[i].rdy);
            chk("vec_start", tx_start, tbl[i].st);
            chk("vec_din",   tx_din,   tbl[i].din);
            chk("vec_busy",  tx_busy,  tbl[i].bsy);
            chk("vec_empty", empty,    tbl[i].emp);
            chk("vec_full",  full,     tbl[i].ful);
            chk("vec_level", level,    tbl[i].lvl);
        end

        // back-to-back bytes, done 40 cycles after each start
        do_reset(40);
        cyc(1'b1, 1'b1, 8'h11, 1'b0, 1'b1, auto_dn());
        cyc(1'b1, 1'b1, 8'h22, 1'b0, 1'b1, auto_dn());
        cyc(1'b1, 1'b1, 8'h33, 1'b0, 1'b1, auto_dn());
        run(200, 1'b1);
        chk("b2b_count", launched.size(), 3);
        if (launched.size() == 3) begin
            chk("b2b_0", launched[0], 8'h11);
            chk("b2b_1", launched[1], 8'h22);
            chk("b2b_2", launched[2], 8'h33);
            // done seen at edge start+40, next launch observed one edge later
            chk("b2b_gap1", start_idx[1] - start_idx[0], 41);
            chk("b2b_gap2", start_idx[2] - start_idx[1], 41);
        end

        // fill to full while paused, then drain
        do_reset(5);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_full",  full,     1'b1);
        chk("fill_level", level,    5'd16);
        chk("fill_rdy",   wr_ready, 1'b0);
        cyc(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("fill_17th",  level,    5'd16);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("fill_rdy_after_pop", wr_ready, 1'b1);
        chk("fill_first", tx_din, 8'h00);
        run(200, 1'b1);
        chk("fill_count", launched.size(), 16);
        for (int i = 0; i < 16 && i < launched.size(); i++) chk("fill_order", launched[i], 8'(i));

        // pointer wrap: 40 bytes in bursts of 10
        do_reset(3);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 8'(b * 10 + i), 1'b0, 1'b1, auto_dn());
            run(80, 1'b1);
        end
        chk("wrap_count", launched.size(), 40);
        for (int i = 0; i < 40 && i < launched.size(); i++) chk("wrap_order", launched[i], 8'(i));
        chk("wrap_level", level, 5'd0);

        // flush during WAIT with a simultaneous write
        do_reset(40);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0, 1'b1, auto_dn());
        for (int i = 0; i < 20 && m_ph != 2; i++) run(1, 1'b1);
        chk("flush_in_wait", tx_busy, 1'b1);
        cyc(1'b1, 1'b1, 8'h99, 1'b1, 1'b1, auto_dn());
        chk("flush_level", level, 5'd0);
        chk("flush_empty", empty, 1'b1);
        chk("flush_busy",  tx_busy, 1'b1);
        run(150, 1'b1);
        chk("flush_count", launched.size(), 1);
        if (launched.size() > 0) chk("flush_byte", launched[0], 8'h01);
        chk("flush_idle", tx_busy, 1'b0);

        // reset mid-frame, then a stray done
        do_reset(0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20 && m_ph != 2; i++) run(1, 1'b1);
        chk("rst_queued", level, 5'd3);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("rst_level", level, 5'd0);
        chk("rst_busy",  tx_busy, 1'b0);
        chk("rst_din",   tx_din, 8'h00);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        run(10, 1'b1);
        chk("rst_launches", launched.size(), 1);

        // randomized traffic against the reference
        do_reset(0);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 400) != 0,
                1'($urandom % 2),
                8'($urandom),
                ($urandom % 40) == 0,
                ($urandom % 8) != 0,
                (m_ph == 2) ? (($urandom % 3) == 0) : (($urandom % 25) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
